// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, width defaults and opcode ranges.
package ifu_pkg;

   localparam int IFU_INS_W   = 64;
   localparam int IFU_IADDR_W = 12;
   localparam int IFU_CNT_W   = 16;

   localparam logic [1:0] IFU_IDLE  = 2'd0;
   localparam logic [1:0] IFU_FETCH = 2'd1;
   localparam logic [1:0] IFU_DRAIN = 2'd2;
   localparam logic [1:0] IFU_WFI   = 2'd3;

   // Opcode lives in the top six bits of every instruction word.
   localparam int OPC_MSB = 63;
   localparam int OPC_LSB = 58;

   localparam logic [5:0] OPC_NOP       = 6'h00;
   localparam logic [5:0] OPC_ALU_FIRST = 6'h01;
   localparam logic [5:0] OPC_ALU_LAST  = 6'h1F;
   localparam logic [5:0] OPC_MEM_FIRST = 6'h20;
   localparam logic [5:0] OPC_MEM_LAST  = 6'h3D;
   localparam logic [5:0] OPC_WFI       = 6'h3F;

   function automatic logic isWfi(input logic [IFU_INS_W-1:0] ins);
      return ins[OPC_MSB:OPC_LSB] == OPC_WFI;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous in-order FIFO with push/pop, occupancy count and head word; storage clears on reset.
module ifu_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] cnt_q;
   logic          full;

   assign full    = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign head_o  = mem_q[rdPtr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (push_i) begin
            mem_q[wrPtr_q] <= data_i;
            wrPtr_q        <= wrPtr_q + AW'(1);
         end
         if (pop_i) rdPtr_q <= rdPtr_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push_i && full));
   assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: SRAM reads into a small FIFO feeding decode, with WFI halt/resume.
// Optional IFU_PERF_CNT_EN adds saturating stall and WFI cycle counters.
module ifu
   import ifu_pkg::*;
#(
   parameter int IADDR_W = IFU_IADDR_W,
   parameter int INS_W   = IFU_INS_W,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = IFU_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               host_ifu_start,
   input  logic [IADDR_W-1:0] host_ifu_base_addr,
   input  logic [CNT_W-1:0]   host_ifu_ins_num,
   input  logic               host_ifu_resume,
   output logic               ifu_host_busy,
   output logic               ifu_host_done,
   output logic               ifu_iram_req,
   output logic [IADDR_W-1:0] ifu_iram_addr,
   input  logic [INS_W-1:0]   iram_ifu_rdata,
   output logic               ifu_idu_vld,
   output logic [INS_W-1:0]   ifu_idu_ins,
   input  logic               idu_ifu_rdy,
   input  logic               idu_ifu_wfi
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]        ifu_perf_stall_cnt,
   output logic [31:0]        ifu_perf_wfi_cnt
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [1:0]         state_q, state_d;
   logic [IADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]   issue_q, issue_d;
   logic [CNT_W-1:0]   deliver_q, deliver_d;
   logic               inflight_q;
   logic               done_q, done_d;

   logic [CW-1:0]      fifoCnt;
   logic               fifoEmpty;
   logic               pop, req, startOk;
   logic [CW:0]        occ;

   ifu_fifo #(.W(INS_W), .DEPTH(DEPTH)) uFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .data_i  (iram_ifu_rdata),
      .pop_i   (pop),
      .head_o  (ifu_idu_ins),
      .count_o (fifoCnt),
      .empty_o (fifoEmpty)
   );

   assign startOk     = (state_q == IFU_IDLE) & host_ifu_start;
   assign ifu_idu_vld = ~fifoEmpty & (state_q != IFU_WFI);
   assign pop         = ifu_idu_vld & idu_ifu_rdy;

   // Counting the same-cycle pop lets a full pipeline sustain one read per cycle.
   assign occ = (CW+1)'(fifoCnt) + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign req = (state_q == IFU_FETCH) & (issue_q != '0) & (occ < (CW+1)'(DEPTH));

   assign ifu_iram_req  = req;
   assign ifu_iram_addr = addr_q;
   assign ifu_host_busy = state_q != IFU_IDLE;
   assign ifu_host_done = done_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      issue_d   = issue_q;
      deliver_d = deliver_q;
      done_d    = 1'b0;
      if (req) begin
         addr_d  = addr_q + IADDR_W'(1);
         issue_d = issue_q - CNT_W'(1);
      end
      if (pop) deliver_d = deliver_q - CNT_W'(1);
      case (state_q)
         IFU_IDLE: begin
            if (host_ifu_start) begin
               if (host_ifu_ins_num != '0) begin
                  state_d   = IFU_FETCH;
                  addr_d    = host_ifu_base_addr;
                  issue_d   = host_ifu_ins_num;
                  deliver_d = host_ifu_ins_num;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         IFU_FETCH, IFU_DRAIN: begin
            if (pop && deliver_q == CNT_W'(1)) begin
               state_d = IFU_IDLE;
               done_d  = 1'b1;
            end else if (idu_ifu_wfi) begin
               state_d = IFU_WFI;
            end else if (issue_d == '0) begin
               state_d = IFU_DRAIN;
            end
         end
         IFU_WFI: begin
            if (host_ifu_resume) state_d = (issue_q != '0) ? IFU_FETCH : IFU_DRAIN;
         end
         default: state_d = IFU_IDLE;
      endcase
   end

   // Clearing inflight on reset discards any SRAM response still on its way.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IFU_IDLE;
         addr_q     <= '0;
         issue_q    <= '0;
         deliver_q  <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         issue_q    <= issue_d;
         deliver_q  <= deliver_d;
         inflight_q <= req;
         done_q     <= done_d;
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] stallCnt_q, wfiCnt_q;

   always_ff @(posedge clk) begin
      if (rst || startOk) begin
         stallCnt_q <= '0;
         wfiCnt_q   <= '0;
      end else begin
         if (ifu_idu_vld && !idu_ifu_rdy && stallCnt_q != '1) stallCnt_q <= stallCnt_q + 32'd1;
         if (state_q == IFU_WFI && wfiCnt_q != '1) wfiCnt_q <= wfiCnt_q + 32'd1;
      end
   end

   assign ifu_perf_stall_cnt = stallCnt_q;
   assign ifu_perf_wfi_cnt   = wfiCnt_q;
`else
   logic unusedStart;
   assign unusedStart = startOk;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: streaming, back-pressure, WFI halt/resume, wrap, reset and zero-count starts.
module tb_ifu;
   import ifu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_ifu_start = 1'b0;
   logic [11:0] host_ifu_base_addr = '0;
   logic [15:0] host_ifu_ins_num = '0;
   logic        host_ifu_resume = 1'b0;
   logic        ifu_host_busy, ifu_host_done, ifu_iram_req;
   logic [11:0] ifu_iram_addr;
   logic [63:0] iram_ifu_rdata = '0;
   logic        ifu_idu_vld;
   logic [63:0] ifu_idu_ins;
   logic        idu_ifu_rdy = 1'b1;
   logic        idu_ifu_wfi = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int startCyc = 0;

   logic        wfiOn = 1'b0;
   logic [11:0] wfiAddr = 12'h022;

   ifu dut (
      .clk                (clk),
      .rst                (rst),
      .host_ifu_start     (host_ifu_start),
      .host_ifu_base_addr (host_ifu_base_addr),
      .host_ifu_ins_num   (host_ifu_ins_num),
      .host_ifu_resume    (host_ifu_resume),
      .ifu_host_busy      (ifu_host_busy),
      .ifu_host_done      (ifu_host_done),
      .ifu_iram_req       (ifu_iram_req),
      .ifu_iram_addr      (ifu_iram_addr),
      .iram_ifu_rdata     (iram_ifu_rdata),
      .ifu_idu_vld        (ifu_idu_vld),
      .ifu_idu_ins        (ifu_idu_ins),
      .idu_ifu_rdy        (idu_ifu_rdy),
      .idu_ifu_wfi        (idu_ifu_wfi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM contents: the address is embedded in each word so delivery order is visible.
   function automatic logic [63:0] memWord(input logic [11:0] a);
      if (wfiOn && a == wfiAddr) return {OPC_WFI, 22'h155555, 24'h0, a};
      return {OPC_ALU_FIRST, 22'h155555, 24'h0, a};
   endfunction

   always @(posedge clk) if (ifu_iram_req) iram_ifu_rdata <= memWord(ifu_iram_addr);

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Monitor sampled at negedge, away from the active edge.
   logic [11:0] reqQ[$];
   int          reqCycQ[$];
   logic [63:0] popQ[$];
   int          popCycQ[$];
   int          doneCnt = 0, doneCyc = -1, firstVld = -1, maxOcc = 0, occ = 0;
   logic        busyAtDone = 1'b0;
   logic        prevStall = 1'b0;
   logic [63:0] prevIns = '0;
   logic        clearReq = 1'b0;

   always @(negedge clk) begin
      if (clearReq) begin
         reqQ.delete(); reqCycQ.delete(); popQ.delete(); popCycQ.delete();
         doneCnt = 0; doneCyc = -1; firstVld = -1; maxOcc = 0; occ = 0; prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("stall vld", {63'b0, ifu_idu_vld}, 64'd1);
            checkOutput("stall ins", ifu_idu_ins, prevIns);
         end
         if (ifu_iram_req) begin
            reqQ.push_back(ifu_iram_addr); reqCycQ.push_back(cyc); occ++;
         end
         if (ifu_idu_vld && firstVld < 0) firstVld = cyc;
         if (ifu_idu_vld && idu_ifu_rdy) begin
            popQ.push_back(ifu_idu_ins); popCycQ.push_back(cyc); occ--;
         end
         if (occ > maxOcc) maxOcc = occ;
         if (ifu_host_done) begin
            doneCnt++; doneCyc = cyc; busyAtDone = ifu_host_busy;
         end
         prevStall = !rst && ifu_idu_vld && !idu_ifu_rdy && !idu_ifu_wfi;
         prevIns   = ifu_idu_ins;
      end
   end

   task automatic clearMon();
      clearReq = 1'b1;
      @(negedge clk);
      #1 clearReq = 1'b0;
   endtask

   task automatic applyStimulus(input logic [11:0] base, input logic [15:0] num);
      @(posedge clk); #1;
      host_ifu_base_addr = base;
      host_ifu_ins_num   = num;
      host_ifu_start     = 1'b1;
      startCyc           = cyc;
      @(posedge clk); #1;
      host_ifu_start = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while (ifu_host_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " idle timeout"}, {63'b0, n >= budget}, 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic checkRun(input string tag, input logic [11:0] base, input int num);
      logic [11:0] a;
      checkOutput({tag, " req count"}, 64'(reqQ.size()), 64'(num));
      checkOutput({tag, " pop count"}, 64'(popQ.size()), 64'(num));
      checkOutput({tag, " done count"}, 64'(doneCnt), 64'd1);
      for (int i = 0; i < num; i++) begin
         a = base + 12'(i);
         if (i < reqQ.size()) checkOutput({tag, " req addr"}, 64'(reqQ[i]), 64'(a));
         if (i < popQ.size()) checkOutput({tag, " pop ins"}, popQ[i], memWord(a));
      end
   endtask

   initial begin
      int vldHigh, reqsInWfi;
      logic found;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst busy", {63'b0, ifu_host_busy}, 64'd0);
      checkOutput("rst vld",  {63'b0, ifu_idu_vld}, 64'd0);
      checkOutput("rst req",  {63'b0, ifu_iram_req}, 64'd0);
      checkOutput("rst done", {63'b0, ifu_host_done}, 64'd0);
      checkOutput("rst addr", 64'(ifu_iram_addr), 64'd0);
      checkOutput("rst ins",  ifu_idu_ins, 64'd0);

      // Streaming: reqs at S+1..S+3, first vld at S+3 (one cycle to FETCH, one of SRAM latency,
      // one to land in the FIFO), pops at S+3..S+5, done at S+6 with busy already low.
      clearMon();
      applyStimulus(12'h010, 16'd3);
      waitIdle("T1", 50);
      checkRun("T1", 12'h010, 3);
      checkOutput("T1 req cyc0", 64'(reqCycQ[0]), 64'(startCyc + 1));
      checkOutput("T1 req cyc2", 64'(reqCycQ[2]), 64'(startCyc + 3));
      checkOutput("T1 first vld", 64'(firstVld), 64'(startCyc + 3));
      checkOutput("T1 last pop", 64'(popCycQ[2]), 64'(startCyc + 5));
      checkOutput("T1 done cyc", 64'(doneCyc), 64'(startCyc + 6));
      checkOutput("T1 busy at done", {63'b0, busyAtDone}, 64'd0);

      // Back-pressure: rdy low for the first 5 cycles of vld.
      clearMon();
      idu_ifu_rdy = 1'b0;
      applyStimulus(12'h000, 16'd6);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (ifu_idu_vld) found = 1'b1;
      end
      checkOutput("T2 vld seen", {63'b0, found}, 64'd1);
      repeat (5) @(posedge clk);
      #1 idu_ifu_rdy = 1'b1;
      waitIdle("T2", 80);
      checkRun("T2", 12'h000, 6);
      checkOutput("T2 max occupancy", 64'(maxOcc), 64'd2);

      // WFI: third word is WFI; decode raises wfi and drops rdy the cycle after taking it.
      clearMon();
      wfiOn = 1'b1;
      applyStimulus(12'h020, 16'd8);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if (ifu_idu_vld && idu_ifu_rdy && isWfi(ifu_idu_ins)) found = 1'b1;
      end
      checkOutput("T3 wfi popped", {63'b0, found}, 64'd1);
      @(posedge clk); #1;
      idu_ifu_wfi = 1'b1; idu_ifu_rdy = 1'b0;
      @(posedge clk); #1;
      idu_ifu_wfi = 1'b0; idu_ifu_rdy = 1'b1;
      vldHigh = 0; reqsInWfi = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifu_idu_vld) vldHigh++;
         if (ifu_iram_req) reqsInWfi++;
      end
      checkOutput("T3 vld in wfi", 64'(vldHigh), 64'd0);
      checkOutput("T3 req in wfi", 64'(reqsInWfi), 64'd0);
      checkOutput("T3 busy in wfi", {63'b0, ifu_host_busy}, 64'd1);
      @(posedge clk); #1 host_ifu_resume = 1'b1;
      @(posedge clk); #1 host_ifu_resume = 1'b0;
      @(negedge clk);
      checkOutput("T3 vld after resume", {63'b0, ifu_idu_vld}, 64'd1);
      checkOutput("T3 ins after resume", ifu_idu_ins, memWord(12'h023));
      waitIdle("T3", 80);
      checkRun("T3", 12'h020, 8);
      wfiOn = 1'b0;

      // Address wrap
      clearMon();
      applyStimulus(12'hFFF, 16'd2);
      waitIdle("T4", 50);
      checkRun("T4", 12'hFFF, 2);

      // Reset the cycle after a req; the in-flight word must never appear.
      clearMon();
      applyStimulus(12'h040, 16'd4);
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clk);
         if (ifu_iram_req) found = 1'b1;
      end
      checkOutput("T5 req seen", {63'b0, found}, 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      clearMon();
      repeat (6) @(negedge clk);
      checkOutput("T5 pops after rst", 64'(popQ.size()), 64'd0);
      checkOutput("T5 reqs after rst", 64'(reqQ.size()), 64'd0);
      checkOutput("T5 vld seen", 64'(firstVld), 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("T5 busy", {63'b0, ifu_host_busy}, 64'd0);
      checkOutput("T5 ins", ifu_idu_ins, 64'd0);

      // Zero-count start, then a start while busy that must be ignored.
      clearMon();
      applyStimulus(12'h100, 16'd0);
      waitIdle("T6a", 10);
      checkOutput("T6 zero reqs", 64'(reqQ.size()), 64'd0);
      checkOutput("T6 zero done count", 64'(doneCnt), 64'd1);
      checkOutput("T6 zero done cyc", 64'(doneCyc), 64'(startCyc + 1));
      clearMon();
      applyStimulus(12'h080, 16'd3);
      applyStimulus(12'h300, 16'd5);
      waitIdle("T6b", 50);
      checkRun("T6b", 12'h080, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
